// File: rtl/fetch_sequencer.sv
// fetch_sequencer: byte-serial instruction fetch front end.
//
// Reads an opcode byte at pc, then up to two operand bytes at pc+1 and pc+2
// (little-endian), presents the completed instruction to the decoder and
// computes the program counter's next value. The program counter register
// itself lives outside this block: it loads next_pc on every rising edge.
//
// Optional feature macro: FETCH_REL_BRANCH_EN
//   defined   : opcode class 2'b11 is 2 bytes; a taken branch of that class
//               jumps to pc + 2 + sign-extended operand[7:0].
//   undefined : opcode class 2'b11 is 3 bytes and uses branch_target.
//
// Handshakes (valid/ready):
//   memory  : mem_req is the valid; mem_ack is the ready/data-valid. A byte
//             transfers only in a cycle where mem_req && mem_ack. mem_req and
//             mem_addr are held stable until that cycle; mem_ack is ignored
//             whenever mem_req is low.
//   decoder : instr_valid is the valid; instr_ready is the ready. The
//             instruction transfers in the cycle instr_valid && instr_ready
//             (the accept cycle). opcode/operand are held stable while
//             instr_valid is high and instr_valid never drops before accept.
module fetch_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic [15:0] next_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  opcode,
  output logic [15:0] operand,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  len_q;       // instruction length in bytes, 1..3
  logic [7:0]  opcode_q;
  logic [15:0] operand_q;
  logic        byte_take;   // a memory byte transfers this cycle
  logic        accept;      // the decoder takes the instruction this cycle
  logic        rel_branch;  // taken branch uses the pc-relative form

  // Length of an instruction given its opcode byte.
  function automatic logic [1:0] decode_len(input logic [7:0] op);
    logic [1:0] len;
    case (op[7:6])
      2'b00:   len = 2'd1;
      2'b01:   len = 2'd2;
      2'b10:   len = 2'd3;
`ifdef FETCH_REL_BRANCH_EN
      default: len = 2'd2;
`else
      default: len = 2'd3;
`endif
    endcase
    return len;
  endfunction

  assign byte_take = mem_req & mem_ack;
  assign accept    = instr_valid & instr_ready;
  assign opcode    = opcode_q;
  assign operand   = operand_q;
  assign state_dbg = state;

`ifdef FETCH_REL_BRANCH_EN
  assign rel_branch = (opcode_q[7:6] == 2'b11);
`else
  assign rel_branch = 1'b0;
`endif

  // State register; reset always returns to a fresh opcode fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH_OP;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus memory request and valid outputs.
  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    mem_addr    = pc;
    instr_valid = 1'b0;
    case (state)
      FETCH_OP: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) begin
          state_nxt = (decode_len(mem_rdata) > 2'd1) ? FETCH_LO : HOLD;
        end
      end
      FETCH_LO: begin
        mem_req  = 1'b1;
        mem_addr = pc + 16'd1;
        if (mem_ack) begin
          state_nxt = (len_q == 2'd3) ? FETCH_HI : HOLD;
        end
      end
      FETCH_HI: begin
        mem_req  = 1'b1;
        mem_addr = pc + 16'd2;
        if (mem_ack) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_nxt = FETCH_OP;
        end
      end
      default: begin
        state_nxt = FETCH_OP;
      end
    endcase
    // No memory traffic while reset is asserted.
    if (reset) begin
      mem_req = 1'b0;
    end
  end

  // Capture instruction bytes as they arrive; a new opcode clears the operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q  <= 8'h00;
      operand_q <= 16'h0000;
      len_q     <= 2'd1;
    end else if (byte_take) begin
      case (state)
        FETCH_OP: begin
          opcode_q  <= mem_rdata;
          operand_q <= 16'h0000;
          len_q     <= decode_len(mem_rdata);
        end
        FETCH_LO: operand_q[7:0]  <= mem_rdata;
        FETCH_HI: operand_q[15:8] <= mem_rdata;
        default:  ;
      endcase
    end
  end

  // Program counter update: hold pc except in the accept cycle.
  always_comb begin
    next_pc = pc;
    if (reset) begin
      next_pc = 16'h0000;
    end else if (accept) begin
      if (branch_taken && rel_branch) begin
        next_pc = pc + 16'd2 + {{8{operand_q[7]}}, operand_q[7:0]};
      end else if (branch_taken) begin
        next_pc = branch_target;
      end else begin
        next_pc = pc + {14'd0, len_q};
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer
// against a byte-array memory and an instruction-level reference model.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] pc = 16'h0000;
  logic [15:0] next_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [1:0]  state_dbg;

  logic        pc_set_en;
  logic [15:0] pc_set_val;
  logic [7:0]  mem [0:65535];
  logic [15:0] m_pc;
  int          checks;
  int          failures;
  int          vcyc;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .next_pc       (next_pc),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .operand       (operand),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .state_dbg     (state_dbg)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program counter register; the bench can preload it while in reset.
  always @(posedge clk) begin
    pc <= pc_set_en ? pc_set_val : next_pc;
  end

  // Reference model: instruction length from the opcode class.
  function automatic int instr_len(input logic [7:0] op);
    case (op[7:6])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 3;
`ifdef FETCH_REL_BRANCH_EN
      default: return 2;
`else
      default: return 3;
`endif
    endcase
  endfunction

  // Reference model: pc after the instruction is accepted.
  function automatic logic [15:0] expect_next(input logic [15:0] p, input logic [7:0] op,
                                              input logic [15:0] opnd, input bit taken,
                                              input logic [15:0] target);
    if (!taken) return p + 16'(instr_len(op));
`ifdef FETCH_REL_BRANCH_EN
    if (op[7:6] == 2'b11) return p + 16'd2 + {{8{opnd[7]}}, opnd[7:0]};
`endif
    return target;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reset for ncyc edges, preloading pc with addr; ends just after a negedge.
  task automatic do_reset(input logic [15:0] addr, input int ncyc);
    reset = 1'b1;
    pc_set_en = 1'b1;
    pc_set_val = addr;
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      #1;
      check("rst_next_pc", next_pc, 32'h0);
      check("rst_mem_req", mem_req, 32'h0);
      @(negedge clk);
    end
    #1;
    check("rst_valid", instr_valid, 32'h0);
    check("rst_opcode", opcode, 32'h0);
    check("rst_operand", operand, 32'h0);
    reset = 1'b0;
    pc_set_en = 1'b0;
    mem_ack = 1'b0;
    #1;
    check("rel_mem_req", mem_req, 32'h1);
    check("rel_mem_addr", mem_addr, 32'(addr));
    check("rel_next_pc", next_pc, 32'(addr));
    m_pc = addr;
  endtask

  // Fetch and retire one instruction at m_pc; ends just after a negedge.
  task automatic exec_instr(input int dmin, input int dmax, input int rdly, input bit taken,
                            input logic [15:0] target, output int vcycles);
    logic [7:0]  op;
    logic [15:0] opnd;
    logic [15:0] addr;
    logic [15:0] exp_next;
    int          len;
    int          d;
    bit          last;
    op = mem[m_pc];
    len = instr_len(op);
    opnd = 16'h0000;
    addr = m_pc + 16'd1;
    if (len >= 2) opnd[7:0] = mem[addr];
    addr = m_pc + 16'd2;
    if (len == 3) opnd[15:8] = mem[addr];
    exp_next = expect_next(m_pc, op, opnd, taken, target);
    for (int i = 0; i < len; i++) begin
      addr = m_pc + 16'(i);
      d = $urandom_range(dmax, dmin);
      for (int k = 0; k <= d; k++) begin
        mem_ack = (k == d);
        mem_rdata = (k == d) ? mem[addr] : 8'($urandom);
        instr_ready = 1'($urandom_range(0, 1));
        branch_taken = 1'($urandom_range(0, 1));
        branch_target = 16'($urandom);
        #1;
        check("fetch_req", mem_req, 32'h1);
        check("fetch_addr", mem_addr, 32'(addr));
        check("fetch_valid", instr_valid, 32'h0);
        check("fetch_next_pc", next_pc, 32'(m_pc));
        @(negedge clk);
      end
    end
    vcycles = 0;
    for (int k = 0; k <= rdly; k++) begin
      last = (k == rdly);
      instr_ready = last;
      branch_taken = last ? taken : 1'($urandom_range(0, 1));
      branch_target = last ? target : 16'($urandom);
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      #1;
      if (instr_valid) vcycles++;
      check("hold_valid", instr_valid, 32'h1);
      check("hold_mem_req", mem_req, 32'h0);
      check("hold_opcode", opcode, 32'(op));
      check("hold_operand", operand, 32'(opnd));
      check(last ? "accept_next_pc" : "hold_next_pc", next_pc, last ? 32'(exp_next) : 32'(m_pc));
      @(negedge clk);
    end
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    mem_ack = 1'b0;
    m_pc = exp_next;
  endtask

  // Start an instruction and abandon it after a few cycles with random acks.
  task automatic partial_fetch(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      instr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    pc_set_en = 1'b0;
    pc_set_val = 16'h0000;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    branch_target = 16'h0000;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    @(negedge clk);

    // Reset at pc 0000.
    do_reset(16'h0000, 2);

    // Three-byte instruction, immediate acks, not taken.
    mem[16'h1111] = 8'h80; mem[16'h1112] = 8'h34; mem[16'h1113] = 8'h12;
    do_reset(16'h1111, 2);
    exec_instr(0, 0, 0, 1'b0, 16'h0000, vcyc);

    // Two-byte instruction, each byte acknowledged after 3 wait cycles.
    mem[16'h2222] = 8'h40;
    do_reset(16'h2222, 2);
    exec_instr(3, 3, 0, 1'b0, 16'h0000, vcyc);

    // Address wrap across FFFF.
    mem[16'hFFFF] = 8'h80;
    do_reset(16'hFFFF, 2);
    exec_instr(0, 1, 0, 1'b0, 16'h0000, vcyc);

    // Decoder stalls 4 cycles, taken branch to 4444.
    mem[16'h3333] = 8'h81;
    do_reset(16'h3333, 2);
    exec_instr(0, 0, 4, 1'b1, 16'h4444, vcyc);
    check("hold_cycles", 32'(vcyc), 32'd5);

    // Class-11 branch with negative offset byte.
    mem[16'h1000] = 8'hC0; mem[16'h1001] = 8'hFE; mem[16'h1002] = 8'h77;
    do_reset(16'h1000, 2);
    exec_instr(0, 1, 0, 1'b1, 16'h5555, vcyc);

    // Randomized back-to-back stream with occasional mid-instruction reset.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 14) == 0) begin
        partial_fetch($urandom_range(1, 6));
        do_reset(16'($urandom), $urandom_range(1, 3));
      end
      exec_instr(0, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 16'($urandom), vcyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: pc  input  16  current PC from the program counter register.
REQ-004 SHALL have: next_pc  output  16  value the program counter loads on the next edge.
REQ-005 SHALL have: mem_req  output  1  byte read request to instruction memory.
REQ-006 SHALL have: mem_addr  output  16  byte address of the request.
REQ-007 SHALL have: mem_ack  input  1  read data valid this cycle.
REQ-008 SHALL have: mem_rdata  input  8  read byte, sampled only when mem_req and mem_ack are both high.
REQ-009 SHALL have: instr_valid  output  1  complete instruction presented.
REQ-010 SHALL have: instr_ready  input  1  decoder accepts the instruction.
REQ-011 SHALL have: opcode  output  8  and operand  output  16  (little-endian; unused bytes zero).
REQ-012 SHALL have: branch_taken  input  1  and branch_target  input  16  (both valid in the accept cycle).

Function
REQ-013 SHALL implement states FETCH_OP, FETCH_LO, FETCH_HI, HOLD.
REQ-014 SHALL set instruction length from opcode[7:6]: 00 -> 1 byte, 01 -> 2, 10 -> 3, 11 -> per REQ-027/028.
REQ-015 SHALL hold mem_req high in the FETCH_* states, with mem_addr = pc + 0, +1 and +2 respectively, mod 2^16. Address wraps from 16'hFFFF to 16'h0000.
REQ-016 SHALL keep mem_req and mem_addr stable until mem_ack is high; mem_req SHALL be low in HOLD.
REQ-017 SHALL capture the byte on the cycle of mem_ack. It SHALL then move FETCH_OP -> FETCH_LO (len>1) or HOLD (len=1), FETCH_LO -> FETCH_HI (len=3) or HOLD, and FETCH_HI -> HOLD.
REQ-018 SHALL clear operand to 16'h0000 when the opcode byte is captured.
REQ-019 SHALL assert instr_valid only in HOLD. opcode and operand SHALL remain stable while instr_valid is high.
REQ-020 SHALL drive next_pc = pc combinationally in every cycle except the accept cycle (instr_valid & instr_ready).
REQ-021 In the accept cycle, SHALL drive next_pc = branch_taken ? branch_target : pc + len (mod 2^16), then return to FETCH_OP.
REQ-022 SHALL ignore branch_taken and branch_target outside the accept cycle.
REQ-023 SHALL allow back-to-back operation: the first FETCH_OP cycle after accept uses the updated pc.
REQ-024 SHALL ignore mem_ack while mem_req is low.

Reset
REQ-025 While reset is high, SHALL force next_pc = 16'h0000 and mem_req = 0. On the edge, SHALL set state FETCH_OP, instr_valid 0, opcode 8'h00, operand 16'h0000.
REQ-026 Reset mid-fetch or in HOLD SHALL abandon the instruction; no partial byte SHALL be retained.

Configuration
REQ-027 With FETCH_REL_BRANCH_EN defined: opcode[7:6]=11 SHALL be 2 bytes long. A taken branch of this class SHALL drive next_pc = pc + 2 + sign-extended operand[7:0], ignoring branch_target.
REQ-028 Without FETCH_REL_BRANCH_EN: opcode[7:6]=11 SHALL be 3 bytes long and use branch_target like the other classes.

Verification
REQ-029 Reset 2 cycles, pc=0 -> next_pc=0000, mem_req=0; after release mem_req=1, mem_addr=0000.
REQ-030 pc=1111, memory [1111]=80,[1112]=34,[1113]=12, ack each cycle, instr_ready=1, branch_taken=0 -> opcode=80, operand=1234, next_pc=1114 only in accept cycle.
REQ-031 pc=2222, opcode 40, mem_ack delayed 3 cycles per byte -> mem_addr held at 2222 then 2223; next_pc=2222 until accept, then 2224.
REQ-032 pc=FFFF, 3-byte opcode -> mem_addr sequence FFFF, 0000, 0001; non-branch accept gives next_pc=0002.
REQ-033 3333, opcode 81, branch_taken=1, branch_target=4444, instr_ready low 4 cycles then high -> instr_valid held 5 cycles; next_pc=4444 in accept cycle only.
REQ-034 With FETCH_REL_BRANCH_EN, pc=1000, opcode C0, operand byte FE, taken -> next_pc=1000. Without the macro, the same case fetches 3 bytes and next_pc=branch_target.
